// File: rtl/load_agu_pkg.sv
// Shared constants and access-size encoding for the load/store address units.
package load_agu_pkg;

  localparam int unsigned ADDR_LEN = 32;
  localparam int unsigned IMM_LEN  = 12;
  localparam int unsigned LQ_SEL   = 3;
  localparam int unsigned ROB_SEL  = 6;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

endpackage

// File: rtl/agu_align_check.sv
// Alignment check for a memory access: flags misaligned or illegal-size accesses.
// Only the two low address bits matter, so only those are brought in.
module agu_align_check
  import load_agu_pkg::*;
(
  input  logic [1:0] addr_low,
  input  size_e      size,
  output logic       fault
);

  // Fault decode per access size
  always_comb begin
    fault = 1'b0;
    unique case (size)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = addr_low[0];
      SZ_WORD: fault = |addr_low;
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_agu.sv
// Load address-generation unit: S1 adds base + sign-extended offset,
// S2 checks alignment and either updates the LQ or raises an exception to the ROB.
module load_agu
  import load_agu_pkg::*;
#(
  parameter int unsigned ADDR_LEN = load_agu_pkg::ADDR_LEN,
  parameter int unsigned IMM_LEN  = load_agu_pkg::IMM_LEN,
  parameter int unsigned LQ_SEL   = load_agu_pkg::LQ_SEL,
  parameter int unsigned ROB_SEL  = load_agu_pkg::ROB_SEL
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ADDR_LEN-1:0] issue_base,
  input  logic [IMM_LEN-1:0]  issue_offset,
  input  logic [1:0]          issue_size,
  input  logic [LQ_SEL-1:0]   issue_lq_idx,
  input  logic [ROB_SEL-1:0]  issue_rob_idx,
  output logic                address_ready,
  output logic [ADDR_LEN-1:0] calculated_address,
  output logic [LQ_SEL-1:0]   update_lq_idx,
  output logic                exc_valid,
  input  logic                exc_ready,
  output logic [ROB_SEL-1:0]  exc_rob_idx,
  output logic [ADDR_LEN-1:0] exc_addr,
  output logic                agu_empty
);

  logic                s1_valid;
  logic [ADDR_LEN-1:0] s1_addr;
  size_e               s1_size;
  logic [LQ_SEL-1:0]   s1_lq;
  logic [ROB_SEL-1:0]  s1_rob;

  logic                s2_valid;
  logic [ADDR_LEN-1:0] s2_addr;
  size_e               s2_size;
  logic [LQ_SEL-1:0]   s2_lq;
  logic [ROB_SEL-1:0]  s2_rob;

  logic                s2_fault;
  logic                s2_aligned;
  logic                s2_free;
  logic                s1_adv;
  logic                accept;
  logic [ADDR_LEN-1:0] offset_ext;

  agu_align_check u_align_check (
    .addr_low (s2_addr[1:0]),
    .size     (s2_size),
    .fault    (s2_fault)
  );

  // Handshake: S2 drains on an aligned entry (no LQ backpressure) or an accepted exception
  always_comb begin
    offset_ext         = {{(ADDR_LEN-IMM_LEN){issue_offset[IMM_LEN-1]}}, issue_offset};
    s2_aligned         = s2_valid && !s2_fault;
    s2_free            = !s2_valid || s2_aligned || exc_ready;
    s1_adv             = s1_valid && s2_free;
    issue_ready        = !s1_valid || s2_free;
    accept             = issue_valid && issue_ready;
    address_ready      = s2_aligned;
    calculated_address = s2_addr;
    update_lq_idx      = s2_lq;
    exc_valid          = s2_valid && s2_fault;
    exc_rob_idx        = s2_rob;
    exc_addr           = s2_addr;
    agu_empty          = !s1_valid && !s2_valid;
  end

  // S1: capture the accepted load with its effective address (wraps modulo 2^ADDR_LEN)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_size  <= SZ_BYTE;
      s1_lq    <= '0;
      s1_rob   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_addr  <= issue_base + offset_ext;
      s1_size  <= size_e'(issue_size);
      s1_lq    <= issue_lq_idx;
      s1_rob   <= issue_rob_idx;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: take S1 whenever S2 frees; a stalled exception holds its data unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_size  <= SZ_BYTE;
      s2_lq    <= '0;
      s2_rob   <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_adv) begin
        s2_addr <= s1_addr;
        s2_size <= s1_size;
        s2_lq   <= s1_lq;
        s2_rob  <= s1_rob;
      end
    end
  end

endmodule

// File: tb/tb_load_agu.sv
// Self-checking bench for load_agu: directed scenarios plus randomized traffic
// checked against an in-order scoreboard of accepted loads.
module tb_load_agu;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_base;
  logic [11:0] issue_offset;
  logic [1:0]  issue_size;
  logic [2:0]  issue_lq_idx;
  logic [5:0]  issue_rob_idx;
  logic        address_ready;
  logic [31:0] calculated_address;
  logic [2:0]  update_lq_idx;
  logic        exc_valid;
  logic        exc_ready;
  logic [5:0]  exc_rob_idx;
  logic [31:0] exc_addr;
  logic        agu_empty;

  load_agu dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .issue_valid        (issue_valid),
    .issue_ready        (issue_ready),
    .issue_base         (issue_base),
    .issue_offset       (issue_offset),
    .issue_size         (issue_size),
    .issue_lq_idx       (issue_lq_idx),
    .issue_rob_idx      (issue_rob_idx),
    .address_ready      (address_ready),
    .calculated_address (calculated_address),
    .update_lq_idx      (update_lq_idx),
    .exc_valid          (exc_valid),
    .exc_ready          (exc_ready),
    .exc_rob_idx        (exc_rob_idx),
    .exc_addr           (exc_addr),
    .agu_empty          (agu_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          fault;
    logic [2:0]  lq;
    logic [5:0]  rob;
  } load_t;

  load_t q[$];  // loads accepted and not yet retired, oldest first
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: effective address and legality from plain arithmetic
  function automatic load_t make_ref(input logic [31:0] b, input logic [11:0] o,
                                     input logic [1:0] sz, input logic [2:0] lq,
                                     input logic [5:0] rob);
    load_t  r;
    longint off;
    off = longint'(o);
    if (off >= 2048) off = off - 4096;
    r.addr = 32'(longint'(b) + off);
    case (sz)
      2'd0: r.fault = 1'b0;
      2'd1: r.fault = (r.addr % 2) != 0;
      2'd2: r.fault = (r.addr % 4) != 0;
      default: r.fault = 1'b1;
    endcase
    r.lq  = lq;
    r.rob = rob;
    return r;
  endfunction

  // Compare state-dependent outputs against the oldest outstanding load
  task automatic observe();
    check_eq("agu_empty", agu_empty, (q.size() == 0));
    if (address_ready) begin
      check_eq("ar_pending", (q.size() > 0), 1);
      if (q.size() > 0) begin
        check_eq("ar_kind", q[0].fault, 0);
        check_eq("ar_addr", calculated_address, q[0].addr);
        check_eq("ar_lq", update_lq_idx, q[0].lq);
        void'(q.pop_front());
      end
    end
    if (exc_valid) begin
      check_eq("exc_pending", (q.size() > 0), 1);
      if (q.size() > 0) begin
        check_eq("exc_kind", q[0].fault, 1);
        check_eq("exc_addr", exc_addr, q[0].addr);
        check_eq("exc_rob", exc_rob_idx, q[0].rob);
      end
    end
  endtask

  // One clock cycle: observe, drive, check readiness, update the scoreboard
  task automatic step(input logic v, input logic [31:0] b, input logic [11:0] o,
                      input logic [1:0] sz, input logic [2:0] lq, input logic [5:0] rob,
                      input logic er, input logic fl);
    logic exp_ready;
    @(negedge clk);
    observe();
    issue_valid   = v;
    issue_base    = b;
    issue_offset  = o;
    issue_size    = sz;
    issue_lq_idx  = lq;
    issue_rob_idx = rob;
    exc_ready     = er;
    flush         = fl;
    #1;
    // Two loads in flight with an undelivered faulting head is the only full case
    exp_ready = !(q.size() == 2 && q[0].fault && !er);
    check_eq("issue_ready", issue_ready, exp_ready);
    if (fl) begin
      q.delete();
    end else begin
      if (exc_valid && er && q.size() > 0) void'(q.pop_front());
      if (v && exp_ready) q.push_back(make_ref(b, o, sz, lq, rob));
    end
  endtask

  task automatic idle(input logic er);
    step(1'b0, '0, '0, '0, '0, '0, er, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_base = '0;
    issue_offset = '0; issue_size = '0; issue_lq_idx = '0; issue_rob_idx = '0;
    exc_ready = 1'b1;
    #1;
    check_eq("rst_issue_ready", issue_ready, 1);
    check_eq("rst_empty", agu_empty, 1);
    check_eq("rst_addr_ready", address_ready, 0);
    check_eq("rst_exc_valid", exc_valid, 0);
    check_eq("rst_calc_addr", calculated_address, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic word load, latency two cycles
    step(1'b1, 32'h1000, 12'h004, 2'b10, 3'd3, 6'd17, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("basic_n1_ar", address_ready, 0);
    idle(1'b1);
    check_eq("basic_n2_ar", address_ready, 1);
    check_eq("basic_addr", calculated_address, 32'h0000_1004);
    check_eq("basic_lq", update_lq_idx, 3);

    // Negative offset wrapping below zero
    step(1'b1, 32'h0000_0002, 12'hFFC, 2'b00, 3'd1, 6'd2, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check_eq("wrap_ar", address_ready, 1);
    check_eq("wrap_addr", calculated_address, 32'hFFFF_FFFE);
    check_eq("wrap_exc", exc_valid, 0);
    idle(1'b1);

    // Misaligned half load stalled by the ROB with back-to-back issues behind it
    step(1'b1, 32'h2001, 12'h000, 2'b01, 3'd0, 6'd5, 1'b0, 1'b0);
    step(1'b1, 32'h3000, 12'h000, 2'b10, 3'd1, 6'd6, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b1, 32'h4000, 12'h000, 2'b10, 3'd2, 6'd7, 1'b0, 1'b0);
      check_eq("stall_exc_valid", exc_valid, 1);
      check_eq("stall_exc_addr", exc_addr, 32'h0000_2001);
      check_eq("stall_exc_rob", exc_rob_idx, 5);
      check_eq("stall_issue_ready", issue_ready, 0);
      check_eq("stall_no_ar", address_ready, 0);
    end
    step(1'b1, 32'h4000, 12'h000, 2'b10, 3'd2, 6'd7, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("unstall_ar", address_ready, 1);
    check_eq("unstall_addr", calculated_address, 32'h0000_3000);
    check_eq("unstall_lq", update_lq_idx, 1);
    idle(1'b1);
    idle(1'b1);

    // Streaming: eight aligned loads, one pulse per cycle in order
    for (int unsigned i = 0; i < 10; i++) begin
      step(i < 8, 32'h100 * i, 12'h010, 2'b10, 3'(i), 6'(i), 1'b1, 1'b0);
      if (i >= 2) begin
        check_eq("stream_ar", address_ready, 1);
        check_eq("stream_lq", update_lq_idx, i - 2);
      end
    end
    idle(1'b1);

    // Flush with both stages full and an illegal-size exception pending
    step(1'b1, 32'h3000, 12'h000, 2'b11, 3'd4, 6'd9, 1'b0, 1'b0);
    step(1'b1, 32'h5000, 12'h000, 2'b10, 3'd5, 6'd10, 1'b0, 1'b0);
    step(1'b1, 32'h6000, 12'h000, 2'b10, 3'd6, 6'd11, 1'b0, 1'b0);
    check_eq("ill_exc_valid", exc_valid, 1);
    check_eq("ill_exc_addr", exc_addr, 32'h0000_3000);
    check_eq("ill_exc_rob", exc_rob_idx, 9);
    step(1'b1, 32'h7000, 12'h000, 2'b10, 3'd7, 6'd12, 1'b1, 1'b1);
    idle(1'b1);
    check_eq("flush_exc_valid", exc_valid, 0);
    check_eq("flush_empty", agu_empty, 1);
    check_eq("flush_no_ar", address_ready, 0);
    idle(1'b1);
    check_eq("flush_no_ar2", address_ready, 0);

    // Asynchronous reset in the middle of a stall
    step(1'b1, 32'h2003, 12'h000, 2'b10, 3'd0, 6'd11, 1'b0, 1'b0);
    step(1'b1, 32'h8000, 12'h000, 2'b10, 3'd1, 6'd12, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    check_eq("pre_rst_exc_valid", exc_valid, 1);
    issue_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("midrst_exc_valid", exc_valid, 0);
    check_eq("midrst_issue_ready", issue_ready, 1);
    check_eq("midrst_empty", agu_empty, 1);
    q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic with stalls and occasional flushes
    for (int unsigned i = 0; i < 400; i++) begin
      logic [31:0] b;
      b = $urandom;
      if ($urandom_range(0, 1) == 0) b[1:0] = 2'b00;
      step($urandom_range(0, 9) < 7, b, 12'($urandom), 2'($urandom), 3'($urandom),
           6'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end

    // Drain everything that is still in flight
    for (int unsigned i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
    check_eq("drain_empty", q.size(), 0);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_agu.md
Name: load_agu

Overview:
- Load address-generation unit between the load issue select and the load queue.
- Takes an issued load (base register value, immediate offset, LQ slot, ROB index, access size) and computes the effective address in a 2-stage pipeline.
- Writes aligned addresses into the load queue through its address-update port.
- Reports misaligned or illegal-size loads to the ROB over a valid/ready exception channel; a stalled exception backpressures issue.

Parameters:
- ADDR_LEN, 32, address and base-value width
- IMM_LEN, 12, immediate offset width; sign-extended to ADDR_LEN
- LQ_SEL, 3, load-queue slot index width
- ROB_SEL, 6, ROB index width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous pipeline kill (branch mispredict)
- issue_valid  in  1  load offered this cycle
- issue_ready  out  1  AGU accepts the offered load this cycle
- issue_base  in  ADDR_LEN  base register value
- issue_offset  in  IMM_LEN  signed immediate
- issue_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- issue_lq_idx  in  LQ_SEL  target load-queue slot
- issue_rob_idx  in  ROB_SEL  ROB index of the load
- address_ready  out  1  one-cycle pulse: address valid for the LQ
- calculated_address  out  ADDR_LEN  effective address
- update_lq_idx  out  LQ_SEL  LQ slot to update
- exc_valid  out  1  misalign/illegal exception pending
- exc_ready  in  1  ROB accepts the exception
- exc_rob_idx  out  ROB_SEL  faulting load
- exc_addr  out  ADDR_LEN  faulting address
- agu_empty  out  1  both stages empty

Behaviour:
- Reset (async): s1_valid=0, s2_valid=0; all outputs 0 except agu_empty=1 and issue_ready=1.
- Stage S1 (add): on accept, registers addr = issue_base + sext(issue_offset), modulo 2^ADDR_LEN (wrap, no carry out), plus size, lq_idx and rob_idx.
- Stage S2 (check), registered from S1:
  - size 00: always aligned.
  - size 01: aligned if addr[0]==0.
  - size 10: aligned if addr[1:0]==0.
  - size 11: always a fault.
- Aligned S2 entry: address_ready=1 for exactly one cycle, with calculated_address and update_lq_idx; S2 frees the same cycle. The LQ path has no backpressure.
- Faulting S2 entry: exc_valid=1 with exc_rob_idx and exc_addr, held stable until the cycle exc_ready=1; address_ready stays 0. S2 frees on the exc_valid && exc_ready cycle.
- Handshake and latency:
  - s2_free = !s2_valid || s2_aligned || exc_ready.
  - s1_adv = s1_valid && s2_free.
  - issue_ready = !s1_valid || s2_free (combinational).
  - Accept = issue_valid && issue_ready.
  - Latency: accepted in cycle N → address_ready in cycle N+2 when unstalled.
  - Throughput: 1 load per cycle.
- Stall: a faulting S2 with exc_ready=0 holds S2. S1 then holds and issue_ready drops once S1 is occupied. Held data must not change.
- Flush: synchronous and highest priority. Next cycle s1_valid=s2_valid=0 and address_ready=exc_valid=0. An issue offered in the flush cycle is dropped, even though issue_ready may read 1.
- exc_ready in the flush cycle: the exception is treated as not delivered. Only flush is visible to the ROB.
- Reset mid-stall: all state cleared immediately; exc_valid drops asynchronously.
- agu_empty = !s1_valid && !s2_valid.

Decomposition:
- Shared package/header constants: ADDR_LEN, IMM_LEN, LQ_SEL, ROB_SEL, size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL).
- Sub-module agu_align_check (combinational: addr, size → fault), reused later by the store AGU.
- Pipeline registers and handshake stay in load_agu.

Test Plan:
- Basic: base=0x1000, offset=0x004, size=10, lq=3, rob=17 → cycle N+2: address_ready=1, calculated_address=0x1004, update_lq_idx=3.
- Negative offset and wrap: base=0x00000002, offset=0xFFC (−4), size=00 → address 0xFFFFFFFE, address_ready=1, no exception.
- Misalign with stall: base=0x2001, offset=0, size=01, rob=5, exc_ready=0 for 4 cycles with back-to-back issues:
  - exc_valid=1, exc_addr=0x2001, exc_rob_idx=5, held stable.
  - issue_ready=0 from the second held cycle on.
  - After exc_ready=1, the queued aligned load emits address_ready the next cycle.
- Streaming: 8 consecutive aligned issues → 8 address_ready pulses on consecutive cycles, in order, lq_idx 0..7.
- Flush: flush asserted while S1 and S2 are full and a faulting entry is pending → next cycle exc_valid=0, agu_empty=1, no address_ready for the killed loads.
- Illegal size and reset: size=11 at an aligned address → exception raised. Async reset mid-stall → exc_valid=0, issue_ready=1 immediately.
